// File: rtl/display_compositor.sv
// display_compositor
//   Composites N_LAYERS sprite layers over a camera/black background by fixed
//   priority (layer 0 highest) with an optional per-layer 50% blend, and owns
//   the START/PLAY/WIN/LOSE game-phase FSM that picks the full-screen output.
//   Two-stage pixel pipeline: hcount/vcount/pixel appear 2 cycles after input.
// Ports
//   clk_in, rst_n_in            pixel clock, async active-low reset
//   hcount_in, vcount_in        pixel coordinates
//   nf_in                       new-frame pulse; phase changes commit here only
//   ir_in                       decoded IR code (level)
//   attack_valid_in             attack registered this cycle
//   player/opponent_health_in   health values
//   layer_valid/blend/color_in  per-layer coverage, blend enable, RGB[24i+:24]
//   camera_en_in, camera_pixel_in  background source select and camera RGB
//   start/win/lose_color_in     full-screen pixels for the non-PLAY phases
//   phase_out                   0 START, 1 PLAY, 2 WIN, 3 LOSE
//   hcount_out, vcount_out, pixel_out  pipelined coordinates and composited RGB
module display_compositor #(
  parameter int unsigned N_LAYERS   = 4,
  parameter int unsigned HEALTH_W   = 3,
  parameter int unsigned BORDER_H   = 960,
  parameter int unsigned BORDER_V   = 640,
  parameter logic [31:0] START_KEY0 = 32'h20DF_5BA4,
  parameter logic [31:0] START_KEY1 = 32'h20DF_5AA5,
  parameter logic [31:0] RESET_KEY  = 32'h20DF_10EF
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic                     nf_in,
  input  logic [31:0]              ir_in,
  input  logic                     attack_valid_in,
  input  logic [HEALTH_W-1:0]      player_health_in,
  input  logic [HEALTH_W-1:0]      opponent_health_in,
  input  logic [N_LAYERS-1:0]      layer_valid_in,
  input  logic [N_LAYERS-1:0]      layer_blend_in,
  input  logic [24*N_LAYERS-1:0]   layer_color_in,
  input  logic                     camera_en_in,
  input  logic [23:0]              camera_pixel_in,
  input  logic [23:0]              start_color_in,
  input  logic [23:0]              win_color_in,
  input  logic [23:0]              lose_color_in,
  output logic [1:0]               phase_out,
  output logic [10:0]              hcount_out,
  output logic [9:0]               vcount_out,
  output logic [23:0]              pixel_out
);

  typedef enum logic [1:0] {
    PH_START = 2'd0,
    PH_PLAY  = 2'd1,
    PH_WIN   = 2'd2,
    PH_LOSE  = 2'd3
  } phase_e;

  // ---------------------------------------------------------------------------
  // Game-phase FSM
  // ---------------------------------------------------------------------------
  phase_e phase_q, phase_d;
  phase_e req_phase_q, req_phase_d;
  logic   req_valid_q, req_valid_d;
  logic   ever_attack_q, ever_attack_d;

  phase_e req_now;
  logic   req_now_valid;
  phase_e eff_phase;
  logic   eff_valid;

  always_comb begin
    req_now_valid = 1'b0;
    req_now       = PH_START;
    case (phase_q)
      PH_START: begin
        if (ir_in == START_KEY0 || ir_in == START_KEY1) begin
          req_now_valid = 1'b1;
          req_now       = PH_PLAY;
        end
      end
      PH_PLAY: begin
        // Both healths at zero is a draw: no request, stay in PLAY.
        if (ever_attack_q) begin
          if (player_health_in == '0 && opponent_health_in != '0) begin
            req_now_valid = 1'b1;
            req_now       = PH_LOSE;
          end else if (opponent_health_in == '0 && player_health_in != '0) begin
            req_now_valid = 1'b1;
            req_now       = PH_WIN;
          end
        end
      end
      default: begin
        if (ir_in == RESET_KEY) begin
          req_now_valid = 1'b1;
          req_now       = PH_START;
        end
      end
    endcase
  end

  // A held request takes precedence; a request arriving on the nf_in cycle
  // itself commits straight away without passing through the register.
  always_comb begin
    eff_valid     = req_valid_q | req_now_valid;
    eff_phase     = req_valid_q ? req_phase_q : req_now;
    phase_d       = phase_q;
    req_valid_d   = req_valid_q;
    req_phase_d   = req_phase_q;
    ever_attack_d = ever_attack_q;
    if (nf_in && eff_valid) begin
      phase_d     = eff_phase;
      req_valid_d = 1'b0;
      if (eff_phase == PH_START) ever_attack_d = 1'b0;
    end else if (!req_valid_q && req_now_valid) begin
      req_valid_d = 1'b1;
      req_phase_d = req_now;
    end
    if (phase_q == PH_PLAY && attack_valid_in) ever_attack_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase_q       <= PH_START;
      req_phase_q   <= PH_START;
      req_valid_q   <= 1'b0;
      ever_attack_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      req_phase_q   <= req_phase_d;
      req_valid_q   <= req_valid_d;
      ever_attack_q <= ever_attack_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel stage 1: priority select, single-level blend, border detect
  // ---------------------------------------------------------------------------
  logic [23:0] bg;
  logic        sel_found, sel_blend, below_found;
  logic [23:0] sel_color, below_color;
  logic [23:0] blend_px;
  logic [23:0] comp_d;
  logic        border_d;

  always_comb begin
    bg          = camera_en_in ? camera_pixel_in : '0;
    sel_found   = 1'b0;
    sel_blend   = 1'b0;
    sel_color   = '0;
    below_found = 1'b0;
    below_color = bg;
    for (int unsigned i = 0; i < N_LAYERS; i++) begin
      if (layer_valid_in[i]) begin
        if (!sel_found) begin
          sel_found = 1'b1;
          sel_blend = layer_blend_in[i];
          sel_color = layer_color_in[24*i +: 24];
        end else if (!below_found) begin
          below_found = 1'b1;
          below_color = layer_color_in[24*i +: 24];
        end
      end
    end
    blend_px = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      blend_px[8*c +: 8] =
        8'(({1'b0, sel_color[8*c +: 8]} + {1'b0, below_color[8*c +: 8]}) >> 1);
    end
    if (!sel_found)     comp_d = bg;
    else if (sel_blend) comp_d = blend_px;
    else                comp_d = sel_color;
    border_d = (hcount_in == 11'(BORDER_H) && vcount_in <= 10'(BORDER_V)) ||
               (vcount_in == 10'(BORDER_V) && hcount_in <= 11'(BORDER_H));
  end

  logic [23:0] comp_q, start_q, win_q, lose_q;
  logic        border_q;
  logic [10:0] h1_q;
  logic [9:0]  v1_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      comp_q   <= '0;
      start_q  <= '0;
      win_q    <= '0;
      lose_q   <= '0;
      border_q <= 1'b0;
      h1_q     <= '0;
      v1_q     <= '0;
    end else begin
      comp_q   <= comp_d;
      start_q  <= start_color_in;
      win_q    <= win_color_in;
      lose_q   <= lose_color_in;
      border_q <= border_d;
      h1_q     <= hcount_in;
      v1_q     <= vcount_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel stage 2: full-screen mux on the current phase
  // ---------------------------------------------------------------------------
  logic [23:0] pixel_d;
  logic [23:0] pixel_q;
  logic [10:0] h2_q;
  logic [9:0]  v2_q;

  always_comb begin
    pixel_d = '0;
    case (phase_q)
      PH_START: pixel_d = start_q;
      PH_WIN:   pixel_d = win_q;
      PH_LOSE:  pixel_d = lose_q;
      default:  pixel_d = border_q ? '1 : comp_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_q <= '0;
      h2_q    <= '0;
      v2_q    <= '0;
    end else begin
      pixel_q <= pixel_d;
      h2_q    <= h1_q;
      v2_q    <= v1_q;
    end
  end

  assign phase_out  = phase_q;
  assign pixel_out  = pixel_q;
  assign hcount_out = h2_q;
  assign vcount_out = v2_q;

endmodule

// File: tb/tb_display_compositor.sv
module tb_display_compositor;

  localparam int          N  = 4;
  localparam int          HW = 3;
  localparam logic [31:0] K0 = 32'h20DF_5BA4;
  localparam logic [31:0] K1 = 32'h20DF_5AA5;
  localparam logic [31:0] KR = 32'h20DF_10EF;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [10:0]     hcount = '0;
  logic [9:0]      vcount = '0;
  logic            nf = 1'b0;
  logic [31:0]     ir = '0;
  logic            attack = 1'b0;
  logic [HW-1:0]   php = '0;
  logic [HW-1:0]   ohp = '0;
  logic [N-1:0]    lvalid = '0;
  logic [N-1:0]    lblend = '0;
  logic [24*N-1:0] lcolor = '0;
  logic            cam_en = 1'b0;
  logic [23:0]     cam = '0;
  logic [23:0]     start_c = '0;
  logic [23:0]     win_c = '0;
  logic [23:0]     lose_c = '0;
  logic [1:0]      phase_o;
  logic [10:0]     hcount_o;
  logic [9:0]      vcount_o;
  logic [23:0]     pixel_o;

  always #5 clk = ~clk;

  display_compositor #(
    .N_LAYERS(N),
    .HEALTH_W(HW)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .hcount_in(hcount),
    .vcount_in(vcount),
    .nf_in(nf),
    .ir_in(ir),
    .attack_valid_in(attack),
    .player_health_in(php),
    .opponent_health_in(ohp),
    .layer_valid_in(lvalid),
    .layer_blend_in(lblend),
    .layer_color_in(lcolor),
    .camera_en_in(cam_en),
    .camera_pixel_in(cam),
    .start_color_in(start_c),
    .win_color_in(win_c),
    .lose_color_in(lose_c),
    .phase_out(phase_o),
    .hcount_out(hcount_o),
    .vcount_out(vcount_o),
    .pixel_out(pixel_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: phase as an integer plus an optional pending target
  // (-1 = none); pixel result computed from the list of covering layers.
  // ---------------------------------------------------------------------------
  int          m_phase = 0;
  int          m_pend  = -1;
  bit          m_ever  = 1'b0;
  int          m_req, m_eff, m_old;
  logic [23:0] s1_comp = '0, s1_start = '0, s1_win = '0, s1_lose = '0;
  bit          s1_border = 1'b0;
  logic [10:0] s1_h = '0;
  logic [9:0]  s1_v = '0;
  logic [23:0] e_pix = '0;
  logic [10:0] e_h = '0;
  logic [9:0]  e_v = '0;

  function automatic logic [23:0] ref_comp(input logic [N-1:0] v, input logic [N-1:0] b,
                                           input logic [24*N-1:0] col, input logic ce,
                                           input logic [23:0] cp);
    int          idx[$];
    logic [23:0] bgc, top, bel, r;
    bgc = ce ? cp : 24'h0;
    for (int i = 0; i < N; i++) if (v[i]) idx.push_back(i);
    if (idx.size() == 0) return bgc;
    top = col[24*idx[0] +: 24];
    if (!b[idx[0]]) return top;
    bel = (idx.size() > 1) ? col[24*idx[1] +: 24] : bgc;
    r = '0;
    for (int c = 0; c < 3; c++)
      r[8*c +: 8] = 8'((int'(top[8*c +: 8]) + int'(bel[8*c +: 8])) / 2);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_pend = -1; m_ever = 1'b0;
      s1_comp = '0; s1_start = '0; s1_win = '0; s1_lose = '0; s1_border = 1'b0;
      s1_h = '0; s1_v = '0; e_pix = '0; e_h = '0; e_v = '0;
    end else begin
      m_old = m_phase;
      case (m_old)
        0:       e_pix = s1_start;
        2:       e_pix = s1_win;
        3:       e_pix = s1_lose;
        default: e_pix = s1_border ? 24'hFF_FFFF : s1_comp;
      endcase
      e_h = s1_h;
      e_v = s1_v;
      s1_comp   = ref_comp(lvalid, lblend, lcolor, cam_en, cam);
      s1_border = (int'(hcount) == 960 && int'(vcount) <= 640) ||
                  (int'(vcount) == 640 && int'(hcount) <= 960);
      s1_start = start_c; s1_win = win_c; s1_lose = lose_c;
      s1_h = hcount; s1_v = vcount;
      m_req = -1;
      if (m_old == 0 && (ir == K0 || ir == K1)) m_req = 1;
      if (m_old == 1 && m_ever) begin
        if (php == 0 && ohp != 0) m_req = 3;
        else if (ohp == 0 && php != 0) m_req = 2;
      end
      if (m_old >= 2 && ir == KR) m_req = 0;
      m_eff = (m_pend >= 0) ? m_pend : m_req;
      if (nf && m_eff >= 0) begin
        m_phase = m_eff;
        m_pend  = -1;
        if (m_eff == 0) m_ever = 1'b0;
      end else if (m_pend < 0) begin
        m_pend = m_req;
      end
      if (m_old == 1 && attack) m_ever = 1'b1;
    end
  end

  function automatic logic [46:0] exp_vec();
    return {2'(m_phase), e_pix, e_h, e_v};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_random();
    hcount = 11'($urandom_range(0, 1279));
    vcount = 10'($urandom_range(0, 719));
    case ($urandom_range(0, 7))
      0: hcount = 11'd960;
      1: vcount = 10'd640;
      default: ;
    endcase
    lvalid  = 4'($urandom);
    lblend  = 4'($urandom);
    lcolor  = {$urandom, $urandom, $urandom};
    cam_en  = 1'($urandom);
    cam     = 24'($urandom);
    start_c = 24'($urandom);
    win_c   = 24'($urandom);
    lose_c  = 24'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_random();
    tick();
    tick();
    n_checks++;
    if ({phase_o, pixel_o, hcount_o, vcount_o} !== 47'h0) begin
      n_fail++;
      $display("FAIL reset_state act=%h exp=0", {phase_o, pixel_o, hcount_o, vcount_o});
    end
    rst_n = 1'b1;
    ir = '0;
    attack = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 16; c++) begin
        drive_random();
        nf = (c == 15);
        tick();
        n_checks++;
        if ({phase_o, pixel_o, hcount_o, vcount_o} !== exp_vec()) begin
          n_fail++;
          $display("FAIL reset_idle_model act=%h exp=%h", {phase_o, pixel_o, hcount_o, vcount_o}, exp_vec());
        end
      end
    end
    nf = 1'b0;
    start_c = 24'h5A_3C_C3;
    tick();
    tick();
    n_checks++;
    if (phase_o !== 2'd0 || pixel_o !== 24'h5A_3C_C3) begin
      n_fail++;
      $display("FAIL start_screen act=%0d/%h exp=0/5a3cc3", phase_o, pixel_o);
    end
  endtask

  task automatic test_start_key();
    ir = K1;
    nf = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive_random();
      tick();
      n_checks++;
      if (phase_o !== 2'd0 || {phase_o, pixel_o, hcount_o, vcount_o} !== exp_vec()) begin
        n_fail++;
        $display("FAIL start_key_wait act=%h exp=%h", {phase_o, pixel_o, hcount_o, vcount_o}, exp_vec());
      end
    end
    ir = '0;
    nf = 1'b1;
    tick();
    nf = 1'b0;
    n_checks++;
    if (phase_o !== 2'd1) begin
      n_fail++;
      $display("FAIL start_key_commit act=%0d exp=1", phase_o);
    end
  endtask

  task automatic test_layers();
    attack = 1'b0; php = 3'd5; ohp = 3'd4; ir = '0; nf = 1'b0;
    hcount = 11'd100; vcount = 10'd100; cam_en = 1'b0; cam = 24'h123456;
    lvalid = 4'b0110; lblend = 4'b0000;
    lcolor = {24'h777777, 24'h0000FF, 24'h00FF00, 24'hABCDEF};
    tick();
    tick();
    n_checks++;
    if (pixel_o !== 24'h00FF00) begin
      n_fail++;
      $display("FAIL layer_priority act=%h exp=00ff00", pixel_o);
    end
    lblend = 4'b0010;
    tick();
    tick();
    n_checks++;
    if (pixel_o !== 24'h007F7F) begin
      n_fail++;
      $display("FAIL layer_blend act=%h exp=007f7f", pixel_o);
    end
    lvalid = 4'b1000; lblend = 4'b1000; cam_en = 1'b1; cam = 24'hFF0101;
    tick();
    tick();
    n_checks++;
    if (pixel_o !== 24'hBB3C3C) begin
      n_fail++;
      $display("FAIL blend_over_camera act=%h exp=bb3c3c", pixel_o);
    end
    for (int c = 0; c < 60; c++) begin
      drive_random();
      php = 3'($urandom_range(1, 7));
      ohp = 3'($urandom_range(1, 7));
      nf  = 1'($urandom);
      tick();
      n_checks++;
      if ({phase_o, pixel_o, hcount_o, vcount_o} !== exp_vec()) begin
        n_fail++;
        $display("FAIL layers_random act=%h exp=%h", {phase_o, pixel_o, hcount_o, vcount_o}, exp_vec());
      end
    end
    nf = 1'b0;
  endtask

  task automatic test_border();
    logic [10:0] hs[6] = '{11'd100, 11'd960, 11'd500, 11'd961, 11'd960, 11'd0};
    logic [9:0]  vs[6] = '{10'd100, 10'd100, 10'd640, 10'd640, 10'd641, 10'd640};
    logic [23:0] ex[6] = '{24'h102030, 24'hFFFFFF, 24'hFFFFFF, 24'h102030, 24'h102030, 24'hFFFFFF};
    lvalid = '0; cam_en = 1'b1; cam = 24'h102030;
    for (int k = 0; k < 6; k++) begin
      hcount = hs[k];
      vcount = vs[k];
      tick();
      tick();
      n_checks++;
      if (pixel_o !== ex[k] || hcount_o !== hs[k] || vcount_o !== vs[k]) begin
        n_fail++;
        $display("FAIL border_%0d act=%h@%0d,%0d exp=%h@%0d,%0d", k, pixel_o, hcount_o, vcount_o,
                 ex[k], hs[k], vs[k]);
      end
    end
    lvalid = 4'b0001; lblend = 4'b0000; hcount = 11'd960; vcount = 10'd10;
    tick();
    tick();
    n_checks++;
    if (pixel_o !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL border_over_layer act=%h exp=ffffff", pixel_o);
    end
  endtask

  task automatic test_health();
    hcount = 11'd50; vcount = 10'd50;
    php = 3'd0; ohp = 3'd3; attack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      nf = 1'b1;
      tick();
      nf = 1'b0;
      tick();
    end
    n_checks++;
    if (phase_o !== 2'd1) begin
      n_fail++;
      $display("FAIL no_attack_stay act=%0d exp=1", phase_o);
    end
    attack = 1'b1;
    tick();
    attack = 1'b0;
    tick();
    tick();
    n_checks++;
    if (phase_o !== 2'd1) begin
      n_fail++;
      $display("FAIL lose_wait_nf act=%0d exp=1", phase_o);
    end
    nf = 1'b1;
    tick();
    nf = 1'b0;
    n_checks++;
    if (phase_o !== 2'd3) begin
      n_fail++;
      $display("FAIL lose_commit act=%0d exp=3", phase_o);
    end
    lose_c = 24'h0F1E2D;
    tick();
    tick();
    n_checks++;
    if (pixel_o !== 24'h0F1E2D) begin
      n_fail++;
      $display("FAIL lose_screen act=%h exp=0f1e2d", pixel_o);
    end
    // Back to PLAY, arm ever_attack, then a draw must not end the game.
    ir = KR; nf = 1'b1; tick();
    ir = K0; tick();
    ir = '0; nf = 1'b0;
    php = 3'd2; ohp = 3'd2; attack = 1'b1; tick();
    attack = 1'b0; php = 3'd0; ohp = 3'd0;
    for (int c = 0; c < 3; c++) begin
      nf = 1'b1; tick();
      nf = 1'b0; tick();
    end
    n_checks++;
    if (phase_o !== 2'd1 || phase_o !== 2'(m_phase)) begin
      n_fail++;
      $display("FAIL draw_stay act=%0d exp=1", phase_o);
    end
    php = 3'd2;
    tick();
    nf = 1'b1; tick();
    nf = 1'b0;
    n_checks++;
    if (phase_o !== 2'd2) begin
      n_fail++;
      $display("FAIL win_commit act=%0d exp=2", phase_o);
    end
  endtask

  task automatic test_reset_key();
    ir = 32'h1234_5678;
    nf = 1'b1;
    tick();
    n_checks++;
    if (phase_o !== 2'd2) begin
      n_fail++;
      $display("FAIL other_code_ignored act=%0d exp=2", phase_o);
    end
    ir = KR;
    tick();
    n_checks++;
    if (phase_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_key_same_edge act=%0d exp=0", phase_o);
    end
    ir = K0;
    tick();
    n_checks++;
    if (phase_o !== 2'd1) begin
      n_fail++;
      $display("FAIL start_key_same_edge act=%0d exp=1", phase_o);
    end
    ir = '0;
    php = 3'd0; ohp = 3'd5; attack = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    n_checks++;
    if (phase_o !== 2'd1) begin
      n_fail++;
      $display("FAIL ever_attack_cleared act=%0d exp=1", phase_o);
    end
    nf = 1'b0;
    php = 3'd4;
    for (int c = 0; c < 30; c++) begin
      drive_random();
      php = 3'($urandom_range(1, 7));
      ohp = 3'($urandom_range(1, 7));
      attack = 1'($urandom);
      nf = 1'($urandom);
      tick();
      n_checks++;
      if ({phase_o, pixel_o, hcount_o, vcount_o} !== exp_vec()) begin
        n_fail++;
        $display("FAIL back_to_back act=%h exp=%h", {phase_o, pixel_o, hcount_o, vcount_o}, exp_vec());
      end
    end
    attack = 1'b0;
    nf = 1'b0;
  endtask

  task automatic test_midline_reset();
    drive_random();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({phase_o, pixel_o, hcount_o, vcount_o} !== 47'h0) begin
      n_fail++;
      $display("FAIL midline_reset act=%h exp=0", {phase_o, pixel_o, hcount_o, vcount_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    hcount = 11'd321; vcount = 10'd123; start_c = 24'hABCDEF; ir = '0;
    tick();
    n_checks++;
    if ({phase_o, pixel_o, hcount_o, vcount_o} !== 47'h0) begin
      n_fail++;
      $display("FAIL flush_first act=%h exp=0", {phase_o, pixel_o, hcount_o, vcount_o});
    end
    tick();
    n_checks++;
    if (pixel_o !== 24'hABCDEF || hcount_o !== 11'd321 || vcount_o !== 10'd123 ||
        {phase_o, pixel_o, hcount_o, vcount_o} !== exp_vec()) begin
      n_fail++;
      $display("FAIL first_after_release act=%h exp=%h", {phase_o, pixel_o, hcount_o, vcount_o}, exp_vec());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_key();
    test_layers();
    test_border();
    test_health();
    test_reset_key();
    test_midline_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
